// File: rtl/vend_dispense_ctrl.sv
// rtl/vend_dispense_ctrl.sv - vend decision and change dispenser behind the coin collector
// Ports:
//   i_clk, i_rst        clock, synchronous active-high reset
//   i_collected[31:0]   running total from the collector
//   i_sel_valid, i_sel  product selection strobe and code
//   i_cancel            refund request strobe
//   o_busy              high while a transaction is in progress
//   o_col_rst           one-cycle clear to the collector
//   o_vend, o_product   one-cycle vend pulse, code of last vended product (held)
//   o_coin_100/25/10    one-cycle coin dispense pulses
//   o_insufficient      one-cycle pulse: funds below price
//   o_err               one-cycle pulse: unmatched product code
//   o_done              one-cycle pulse: transaction finished
//   o_residual[3:0]     undispensable remainder of last transaction (held)
module vend_dispense_ctrl #(
  parameter logic [9:0] PRICE_A  = 10'd50,
  parameter logic [9:0] PRICE_B  = 10'd80,
  parameter logic [9:0] PRICE_C  = 10'd100,
  parameter logic [9:0] PRICE_D  = 10'd120,
  parameter logic [9:0] PRICE_E  = 10'd150,
  parameter logic [2:0] A        = 3'b001,
  parameter logic [2:0] B        = 3'b011,
  parameter logic [2:0] C        = 3'b010,
  parameter logic [2:0] D        = 3'b110,
  parameter logic [2:0] E        = 3'b111,
  parameter logic [3:0] COIN_GAP = 4'd2
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [31:0] i_collected,
  input  logic        i_sel_valid,
  input  logic [2:0]  i_sel,
  input  logic        i_cancel,
  output logic        o_busy,
  output logic        o_col_rst,
  output logic        o_vend,
  output logic [2:0]  o_product,
  output logic        o_coin_100,
  output logic        o_coin_25,
  output logic        o_coin_10,
  output logic        o_insufficient,
  output logic        o_err,
  output logic        o_done,
  output logic [3:0]  o_residual
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    CHECK  = 3'd1,
    VEND   = 3'd2,
    CHANGE = 3'd3,
    GAP    = 3'd4,
    DONE   = 3'd5
  } state_t;

  state_t      state, state_n;
  logic [2:0]  code_q, code_n;
  logic [9:0]  price_q, price_n;
  logic [31:0] change_q, change_n;
  logic [3:0]  gap_cnt, gap_n;

  logic        sel_ok;
  logic [9:0]  sel_price;
  logic        pick_100, pick_25, pick_10;
  logic        cancel_take;

  logic        busy_d, col_rst_d, vend_d, coin_100_d, coin_25_d, coin_10_d;
  logic        insufficient_d, err_d, done_d;
  logic [2:0]  product_d;
  logic [3:0]  residual_d;

  // Price table lookup; first matching code wins if parameters ever overlap.
  always_comb begin
    sel_ok    = 1'b1;
    sel_price = PRICE_A;
    if (i_sel == A)      sel_price = PRICE_A;
    else if (i_sel == B) sel_price = PRICE_B;
    else if (i_sel == C) sel_price = PRICE_C;
    else if (i_sel == D) sel_price = PRICE_D;
    else if (i_sel == E) sel_price = PRICE_E;
    else begin
      sel_ok    = 1'b0;
      sel_price = 10'd0;
    end
  end

  // Coin choice: a 25 is only used when it clears a trailing 5, otherwise
  // the remainder could never be paid out in tens.
  always_comb begin
    pick_100 = (change_q >= 32'd100);
    pick_25  = !pick_100 && (change_q >= 32'd25) &&
               ((change_q[6:0] % 7'd10) == 7'd5);
    pick_10  = !pick_100 && !pick_25 && (change_q >= 32'd10);
  end

  assign cancel_take = i_cancel && (i_collected != 32'd0);

  // State register; outputs are registered alongside the transition.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state          <= IDLE;
      code_q         <= 3'd0;
      price_q        <= 10'd0;
      change_q       <= 32'd0;
      gap_cnt        <= 4'd0;
      o_busy         <= 1'b0;
      o_col_rst      <= 1'b0;
      o_vend         <= 1'b0;
      o_product      <= 3'd0;
      o_coin_100     <= 1'b0;
      o_coin_25      <= 1'b0;
      o_coin_10      <= 1'b0;
      o_insufficient <= 1'b0;
      o_err          <= 1'b0;
      o_done         <= 1'b0;
      o_residual     <= 4'd0;
    end else begin
      state          <= state_n;
      code_q         <= code_n;
      price_q        <= price_n;
      change_q       <= change_n;
      gap_cnt        <= gap_n;
      o_busy         <= busy_d;
      o_col_rst      <= col_rst_d;
      o_vend         <= vend_d;
      o_product      <= product_d;
      o_coin_100     <= coin_100_d;
      o_coin_25      <= coin_25_d;
      o_coin_10      <= coin_10_d;
      o_insufficient <= insufficient_d;
      o_err          <= err_d;
      o_done         <= done_d;
      o_residual     <= residual_d;
    end
  end

  // Next-state and datapath
  always_comb begin
    state_n  = state;
    code_n   = code_q;
    price_n  = price_q;
    change_n = change_q;
    gap_n    = gap_cnt;
    case (state)
      IDLE: begin
        // A cancel strobe always swallows a simultaneous selection.
        if (i_cancel) begin
          if (cancel_take) begin
            change_n = i_collected;
            state_n  = CHANGE;
          end
        end else if (i_sel_valid && sel_ok) begin
          code_n  = i_sel;
          price_n = sel_price;
          state_n = CHECK;
        end
      end
      CHECK: begin
        if (i_collected >= {22'd0, price_q}) begin
          change_n = i_collected - {22'd0, price_q};
          state_n  = VEND;
        end else begin
          state_n = IDLE;
        end
      end
      VEND: state_n = CHANGE;
      CHANGE: begin
        if (pick_100 || pick_25 || pick_10) begin
          if (pick_100)     change_n = change_q - 32'd100;
          else if (pick_25) change_n = change_q - 32'd25;
          else              change_n = change_q - 32'd10;
          gap_n   = 4'd0;
          state_n = (COIN_GAP != 4'd0) ? GAP : CHANGE;
        end else begin
          state_n = DONE;
        end
      end
      GAP: begin
        if (gap_cnt == COIN_GAP - 4'd1) state_n = CHANGE;
        else                            gap_n   = gap_cnt + 4'd1;
      end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Output values to be registered with the transition
  always_comb begin
    busy_d         = (state_n != IDLE);
    col_rst_d      = (state_n == VEND) || (state == IDLE && state_n == CHANGE);
    vend_d         = (state_n == VEND);
    product_d      = (state_n == VEND) ? code_q : o_product;
    coin_100_d     = (state == CHANGE) && pick_100;
    coin_25_d      = (state == CHANGE) && pick_25;
    coin_10_d      = (state == CHANGE) && pick_10;
    insufficient_d = (state == CHECK) && (state_n == IDLE);
    err_d          = (state == IDLE) && !i_cancel && i_sel_valid && !sel_ok;
    done_d         = (state_n == DONE);
    residual_d     = (state == CHANGE && state_n == DONE) ? change_q[3:0] : o_residual;
  end

endmodule

// File: tb/tb_vend_dispense_ctrl.sv
// tb/tb_vend_dispense_ctrl.sv - directed vector bench for vend_dispense_ctrl
module tb_vend_dispense_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] collected;
  logic        sel_valid;
  logic [2:0]  sel;
  logic        cancel;
  logic        busy, col_rst, vend, coin_100, coin_25, coin_10;
  logic        insufficient, err, done;
  logic [2:0]  product;
  logic [3:0]  residual;

  vend_dispense_ctrl dut (
    .i_clk(clk), .i_rst(rst), .i_collected(collected), .i_sel_valid(sel_valid),
    .i_sel(sel), .i_cancel(cancel), .o_busy(busy), .o_col_rst(col_rst),
    .o_vend(vend), .o_product(product), .o_coin_100(coin_100), .o_coin_25(coin_25),
    .o_coin_10(coin_10), .o_insufficient(insufficient), .o_err(err), .o_done(done),
    .o_residual(residual)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;

  // Event recorder, sampled on the falling edge
  logic        rec = 1'b0;
  int          n_vend, n_colrst, n_coin, n_insuf, n_err, n_done;
  int          vend_cyc, cr_cyc, last_coin;
  logic [15:0] seq;
  logic        gap_bad, overlap;

  always @(negedge clk) begin
    if (rec) begin
      int coins;
      coins = int'(coin_100) + int'(coin_25) + int'(coin_10);
      if (vend)         begin n_vend++; vend_cyc = cyc; end
      if (col_rst)      begin n_colrst++; cr_cyc = cyc; end
      if (insufficient) n_insuf++;
      if (err)          n_err++;
      if (done)         n_done++;
      if (coins > 1 || (coins > 0 && vend)) overlap = 1'b1;
      if (coins == 1) begin
        seq = {seq[13:0], coin_100 ? 2'd3 : (coin_25 ? 2'd2 : 2'd1)};
        if (n_coin > 0 && (cyc - last_coin) != 3) gap_bad = 1'b1;
        last_coin = cyc;
        n_coin++;
      end
    end
  end

  task automatic clear_rec();
    n_vend = 0; n_colrst = 0; n_coin = 0; n_insuf = 0; n_err = 0; n_done = 0;
    vend_cyc = 0; cr_cyc = 0; last_coin = 0; seq = 16'd0;
    gap_bad = 1'b0; overlap = 1'b0;
  endtask

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic chk_all_zero(input string nm);
    chk(nm, int'({busy, col_rst, vend, product, coin_100, coin_25, coin_10,
                  insufficient, err, done, residual}), 0);
  endtask

  typedef struct {
    logic [31:0] collected;
    logic        sv;
    logic [2:0]  sel;
    logic        cancel;
    int          e_vend;
    int          e_colrst;
    logic [2:0]  e_product;
    logic [15:0] e_seq;
    int          e_ncoin;
    int          e_insuf;
    int          e_err;
    int          e_done;
    logic [3:0]  e_res;
  } vec_t;

  localparam int NV = 14;
  vec_t vt[NV];

  task automatic setv(input int i, input logic [31:0] c, input logic sv, input logic [2:0] s,
                      input logic cn, input int ev, input int ecr, input logic [2:0] ep,
                      input logic [15:0] es, input int enc, input int ei, input int ee,
                      input int ed, input logic [3:0] er);
    vt[i].collected = c;   vt[i].sv = sv;          vt[i].sel = s;        vt[i].cancel = cn;
    vt[i].e_vend = ev;     vt[i].e_colrst = ecr;   vt[i].e_product = ep; vt[i].e_seq = es;
    vt[i].e_ncoin = enc;   vt[i].e_insuf = ei;     vt[i].e_err = ee;     vt[i].e_done = ed;
    vt[i].e_res = er;
  endtask

  task automatic run_vec(input int i);
    string p;
    p = $sformatf("v%0d", i);
    clear_rec();
    rec = 1'b1;
    @(negedge clk);
    collected = vt[i].collected; sel_valid = vt[i].sv; sel = vt[i].sel; cancel = vt[i].cancel;
    begin
      int s_cyc;
      s_cyc = cyc;
      @(negedge clk);
      sel_valid = 1'b0; cancel = 1'b0;
      repeat (38) @(negedge clk);
      rec = 1'b0;
      chk({p, " vend"},    n_vend,   vt[i].e_vend);
      chk({p, " col_rst"}, n_colrst, vt[i].e_colrst);
      chk({p, " ncoin"},   n_coin,   vt[i].e_ncoin);
      chk({p, " coinseq"}, int'(seq), int'(vt[i].e_seq));
      chk({p, " insuff"},  n_insuf,  vt[i].e_insuf);
      chk({p, " err"},     n_err,    vt[i].e_err);
      chk({p, " done"},    n_done,   vt[i].e_done);
      chk({p, " product"}, int'(product),  int'(vt[i].e_product));
      chk({p, " residual"}, int'(residual), int'(vt[i].e_res));
      chk({p, " gap"},     int'(gap_bad), 0);
      chk({p, " overlap"}, int'(overlap), 0);
      chk({p, " busy_end"}, int'(busy), 0);
      if (vt[i].e_vend != 0) chk({p, " vend_lat"}, vend_cyc - s_cyc, 2);
      if (vt[i].e_colrst != 0) chk({p, " colrst_lat"}, cr_cyc - s_cyc, vt[i].cancel ? 1 : 2);
    end
  endtask

  initial begin
    //    idx collected sv sel     cn  vend cr  product seq                              n  ins err done res
    setv(0,  50,  1, 3'b001, 0,  1, 1, 3'b001, 16'd0,                            0, 0, 0, 1, 4'd0);
    setv(1,  235, 1, 3'b011, 0,  1, 1, 3'b011, {6'd0,2'd3,2'd2,2'd1,2'd1,2'd1},  5, 0, 0, 1, 4'd0);
    setv(2,  90,  1, 3'b110, 0,  0, 0, 3'b011, 16'd0,                            0, 1, 0, 0, 4'd0);
    setv(3,  90,  1, 3'b100, 0,  0, 0, 3'b011, 16'd0,                            0, 0, 1, 0, 4'd0);
    setv(4,  45,  1, 3'b001, 1,  0, 1, 3'b011, {10'd0,2'd2,2'd1,2'd1},           3, 0, 0, 1, 4'd0);
    setv(5,  65,  1, 3'b001, 0,  1, 1, 3'b001, {14'd0,2'd1},                     1, 0, 0, 1, 4'd5);
    setv(6,  0,   0, 3'b001, 1,  0, 0, 3'b001, 16'd0,                            0, 0, 0, 0, 4'd5);
    setv(7,  303, 1, 3'b010, 0,  1, 1, 3'b010, {12'd0,2'd3,2'd3},                2, 0, 0, 1, 4'd3);
    setv(8,  127, 1, 3'b110, 0,  1, 1, 3'b110, 16'd0,                            0, 0, 0, 1, 4'd7);
    setv(9,  150, 1, 3'b111, 0,  1, 1, 3'b111, 16'd0,                            0, 0, 0, 1, 4'd0);
    setv(10, 185, 1, 3'b111, 0,  1, 1, 3'b111, {12'd0,2'd2,2'd1},                2, 0, 0, 1, 4'd0);
    setv(11, 200, 1, 3'b000, 0,  0, 0, 3'b111, 16'd0,                            0, 0, 1, 0, 4'd0);
    setv(12, 200, 1, 3'b101, 0,  0, 0, 3'b111, 16'd0,                            0, 0, 1, 0, 4'd0);
    setv(13, 79,  1, 3'b011, 0,  0, 0, 3'b111, 16'd0,                            0, 1, 0, 0, 4'd0);

    clear_rec();
    rst = 1'b1; collected = 32'd0; sel_valid = 1'b0; sel = 3'd0; cancel = 1'b0;

    // Reset with random inputs toggling
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk_all_zero($sformatf("reset%0d outputs", k));
      collected = $urandom_range(0, 300); sel_valid = 1'($urandom);
      sel = 3'($urandom); cancel = 1'($urandom);
    end
    @(negedge clk);
    rst = 1'b0; collected = 32'd0; sel_valid = 1'b0; cancel = 1'b0;
    repeat (3) @(negedge clk);
    chk_all_zero("post-reset idle");

    for (int i = 0; i < NV; i++) run_vec(i);

    // Reset while waiting between coins
    clear_rec();
    rec = 1'b1;
    @(negedge clk);
    collected = 32'd235; sel = 3'b011; sel_valid = 1'b1;
    @(negedge clk);
    sel_valid = 1'b0;
    begin
      int t;
      t = 0;
      while (n_coin == 0 && t < 20) begin
        @(negedge clk);
        t++;
      end
      chk("gap wait for first coin", int'(n_coin > 0), 1);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk_all_zero("midgap reset outputs");
    repeat (20) @(negedge clk);
    rec = 1'b0;
    chk("midgap coins after reset", n_coin, 1);
    chk("midgap done after reset", n_done, 0);
    chk("midgap col_rst count", n_colrst, 1);
    chk("midgap busy", int'(busy), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
